// File: rtl/tone_detect.sv
// Tone detector: measures rising-edge period of a square-wave pin
// and maps it to the buzzer's 4-bit note code.
module tone_detect #(
   parameter int PERIOD_W = 16,
   parameter int TIMEOUT  = 65535,
   parameter int TOL      = 200,
   parameter int CONFIRM  = 2
) (
   input  logic                clk_62p5mhz,
   input  logic                reset,
   input  logic                sig_in,
   output logic [3:0]          note,
   output logic [PERIOD_W-1:0] period,
   output logic                locked,
   output logic                note_chg
);

   typedef enum logic {
      S_IDLE,
      S_MEAS
   } state_t;

   localparam logic [PERIOD_W-1:0] TO  = PERIOD_W'(TIMEOUT);
   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
   localparam logic [2:0]          CF  = 3'(CONFIRM);

   state_t              state;
   logic                sync_d;
   logic                sync_q;
   logic                prev_q;
   logic                rise;
   logic [PERIOD_W-1:0] cnt;
   logic [3:0]          cand;
   logic [2:0]          conf;
   logic [3:0]          code;
   logic [3:0]          cand_nxt;
   logic [2:0]          conf_nxt;

   // nominal period in cycles for note k (1 = C ... 13 = upper C)
   function automatic int nominal(input int k);
      case (k)
         1:       return 2 * 14931 + 1;
         2:       return 2 * 14093 + 1;
         3:       return 2 * 13302 + 1;
         4:       return 2 * 12555 + 1;
         5:       return 2 * 11850 + 1;
         6:       return 2 * 11185 + 1;
         7:       return 2 * 10558 + 1;
         8:       return 2 * 9965 + 1;
         9:       return 2 * 9406 + 1;
         10:      return 2 * 8878 + 1;
         11:      return 2 * 8380 + 1;
         12:      return 2 * 7909 + 1;
         13:      return 2 * 7465 + 1;
         default: return 0;
      endcase
   endfunction

   assign rise = sync_q & ~prev_q;

   // descending scan so the lowest matching note wins
   always_comb begin
      code = 4'd15;
      for (int k = 13; k >= 1; k--) begin
         if ((int'(cnt) - nominal(k) <= TOL) &&
             (nominal(k) - int'(cnt) <= TOL))
            code = 4'(k);
      end
   end

   always_comb begin
      cand_nxt = code;
      conf_nxt = 3'd1;
      if (code == cand) begin
         cand_nxt = cand;
         conf_nxt = (conf >= CF) ? CF : conf + 3'd1;
      end
   end

   always_ff @(posedge clk_62p5mhz or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         sync_d   <= 1'b0;
         sync_q   <= 1'b0;
         prev_q   <= 1'b0;
         cnt      <= '0;
         cand     <= 4'd0;
         conf     <= 3'd0;
         note     <= 4'd0;
         period   <= '0;
         locked   <= 1'b0;
         note_chg <= 1'b0;
      end else begin
         sync_d   <= sig_in;
         sync_q   <= sync_d;
         prev_q   <= sync_q;
         note_chg <= 1'b0;
         unique case (state)
            S_IDLE: begin
               cnt <= '0;
               if (rise) begin
                  state <= S_MEAS;
                  cnt   <= ONE;
                  cand  <= 4'd0;
                  conf  <= 3'd0;
               end
            end
            S_MEAS: begin
               if (rise) begin
                  cnt  <= ONE;
                  cand <= cand_nxt;
                  conf <= conf_nxt;
                  if (conf_nxt == CF) begin
                     period <= cnt;
                     if (cand_nxt != note) begin
                        note     <= cand_nxt;
                        locked   <= 1'b1;
                        note_chg <= 1'b1;
                     end
                  end
               end else if (cnt == TO) begin
                  // tone lost: drop back to idle
                  state <= S_IDLE;
                  cnt   <= '0;
                  cand  <= 4'd0;
                  conf  <= 3'd0;
                  if (note != 4'd0) begin
                     note     <= 4'd0;
                     period   <= '0;
                     locked   <= 1'b0;
                     note_chg <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_detect.sv
// Bench for tone_detect: three default-parameter lanes run note tables,
// a short-timeout lane runs timeout, reset and random-period checks.
module tb_tone_detect;

   localparam int NL      = 4;
   localparam int FAST_TO = 1000;
   localparam int CONF    = 2;
   localparam int TOLV    = 200;
   localparam int NV      = 14;
   localparam int NK [13] = '{14931, 14093, 13302, 12555, 11850, 11185,
                              10558, 9965, 9406, 8878, 8380, 7909, 7465};

   typedef struct {
      int lane;
      int per;
      int en;
      int ep;
      int ec;
   } vec_t;

   logic        clk_62p5mhz = 1'b0;
   logic        reset    [NL];
   logic        sig_in   [NL];
   logic [3:0]  note     [NL];
   logic [15:0] period   [NL];
   logic        locked   [NL];
   logic        note_chg [NL];
   int          chgs     [NL];
   vec_t        tab      [NV];

   int ncmp = 0;
   int nerr = 0;

   int m_active = 0;
   int m_cand   = 0;
   int m_conf   = 0;
   int m_note   = 0;
   int m_period = 0;
   int m_chgs   = 0;
   int f_prev   = -1;

   always #8 clk_62p5mhz = ~clk_62p5mhz;

   for (genvar g = 0; g < 3; g++) begin : gen_std
      tone_detect u_dut (
         .clk_62p5mhz(clk_62p5mhz),
         .reset      (reset[g]),
         .sig_in     (sig_in[g]),
         .note       (note[g]),
         .period     (period[g]),
         .locked     (locked[g]),
         .note_chg   (note_chg[g])
      );
   end

   tone_detect #(.TIMEOUT(FAST_TO)) u_fast (
      .clk_62p5mhz(clk_62p5mhz),
      .reset      (reset[3]),
      .sig_in     (sig_in[3]),
      .note       (note[3]),
      .period     (period[3]),
      .locked     (locked[3]),
      .note_chg   (note_chg[3])
   );

   always @(negedge clk_62p5mhz) begin
      for (int l = 0; l < NL; l++)
         if (note_chg[l] === 1'b1) chgs[l] += 1;
   end

   initial begin
      #(16 * 95000);
      $display("FAIL watchdog: run exceeded cycle budget");
      $fatal(1);
   end

   task automatic cyc(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk_62p5mhz);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input int l, input string tag);
      chk($sformatf("L%0d %s note", l, tag), int'(note[l]), 0);
      chk($sformatf("L%0d %s period", l, tag), int'(period[l]), 0);
      chk($sformatf("L%0d %s locked", l, tag), int'(locked[l]), 0);
      chk($sformatf("L%0d %s note_chg", l, tag), int'(note_chg[l]), 0);
   endtask

   task automatic chk_state(input int l, input string tag,
                            input int en, input int ep, input int ec);
      chk($sformatf("L%0d %s note", l, tag), int'(note[l]), en);
      chk($sformatf("L%0d %s period", l, tag), int'(period[l]), ep);
      chk($sformatf("L%0d %s locked", l, tag), int'(locked[l]),
          (en != 0) ? 1 : 0);
      chk($sformatf("L%0d %s chg_count", l, tag), chgs[l], ec);
   endtask

   // rising edge, check 4 cycles later, then finish a period of per cycles
   task automatic tone_edge(input int l, input int per, input string tag,
                            input int en, input int ep, input int ec);
      int h;
      sig_in[l] = 1'b1;
      cyc(4);
      chk_state(l, tag, en, ep, ec);
      if (per == 0) begin
         sig_in[l] = 1'b0;
      end else begin
         h = per / 2;
         cyc(h - 4);
         sig_in[l] = 1'b0;
         cyc(per - h);
      end
   endtask

   function automatic int classify(input int iv);
      for (int k = 1; k <= 13; k++) begin
         int d;
         d = iv - (2 * NK[k-1] + 1);
         if (d < 0) d = -d;
         if (d <= TOLV) return k;
      end
      return 15;
   endfunction

   function automatic void m_timeout();
      if (m_note != 0) begin
         m_note   = 0;
         m_period = 0;
         m_chgs++;
      end
      m_active = 0;
      m_cand   = 0;
      m_conf   = 0;
   endfunction

   // reference: one rising edge that closes an interval of iv cycles
   function automatic void m_edge(input int iv);
      int c;
      if (iv < 0 || m_active == 0 || iv > FAST_TO) begin
         if (m_active != 0 && iv > FAST_TO) m_timeout();
         m_active = 1;
         m_cand   = 0;
         m_conf   = 0;
         return;
      end
      c = classify(iv);
      if (c == m_cand) begin
         m_conf = (m_conf + 1 > CONF) ? CONF : m_conf + 1;
      end else begin
         m_cand = c;
         m_conf = 1;
      end
      if (m_conf == CONF) begin
         if (m_cand != m_note) begin
            m_note = m_cand;
            m_chgs++;
         end
         m_period = iv;
      end
   endfunction

   task automatic fast_edge(input int per, input string tag);
      m_edge(f_prev);
      tone_edge(3, per, tag, m_note, m_period, m_chgs);
      f_prev = (per == 0) ? -1 : per;
   endtask

   task automatic run_table(input int l);
      for (int i = 0; i < NV; i++) begin
         if (tab[i].lane == l)
            tone_edge(l, tab[i].per, $sformatf("row%0d", i),
                      tab[i].en, tab[i].ep, tab[i].ec);
      end
   endtask

   task automatic run_fast();
      int per;
      // interval exactly TIMEOUT still counts as an edge
      fast_edge(1000, "b1");
      fast_edge(1000, "b2");
      fast_edge(500, "b3");
      fast_edge(0, "b4");
      cyc(998);
      chk("L3 pre_timeout note", int'(note[3]), 15);
      chk("L3 pre_timeout chg", int'(note_chg[3]), 0);
      cyc(1);
      chk("L3 timeout note", int'(note[3]), 0);
      chk("L3 timeout period", int'(period[3]), 0);
      chk("L3 timeout locked", int'(locked[3]), 0);
      chk("L3 timeout chg", int'(note_chg[3]), 1);
      cyc(1);
      chk("L3 post_timeout chg", int'(note_chg[3]), 0);
      m_timeout();
      chk("L3 timeout chg_count", chgs[3], m_chgs);

      // reset partway through a period
      fast_edge(700, "r1");
      fast_edge(700, "r2");
      fast_edge(0, "r3");
      cyc(300);
      reset[3] = 1'b1;
      cyc(1);
      chk_zero(3, "mid_rst");
      cyc(3);
      reset[3] = 1'b0;
      cyc(1);
      chk_zero(3, "mid_rel");
      m_active = 0;
      m_cand   = 0;
      m_conf   = 0;
      m_note   = 0;
      m_period = 0;
      f_prev   = -1;
      fast_edge(650, "q1");
      fast_edge(650, "q2");
      fast_edge(400, "q3");

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 7) per = $urandom_range(10, 400);
         else per = $urandom_range(950, 1060);
         fast_edge(per, $sformatf("rnd%0d", i));
      end
      fast_edge(0, "rnd_end");
      cyc(1100);
      m_timeout();
      chk_state(3, "silent_end", m_note, m_period, m_chgs);
   endtask

   initial begin
      tab[0]  = '{0, 14931, 0, 0, 0};
      tab[1]  = '{0, 14931, 0, 0, 0};
      tab[2]  = '{0, 15132, 13, 14931, 1};
      tab[3]  = '{0, 15131, 13, 14931, 1};
      tab[4]  = '{0, 14731, 13, 14931, 1};
      tab[5]  = '{0, 0, 13, 14731, 1};
      tab[6]  = '{1, 17957, 0, 0, 0};
      tab[7]  = '{1, 17557, 0, 0, 0};
      tab[8]  = '{1, 14931, 10, 17557, 1};
      tab[9]  = '{1, 14931, 10, 17557, 1};
      tab[10] = '{1, 0, 13, 14931, 2};
      tab[11] = '{2, 30063, 0, 0, 0};
      tab[12] = '{2, 29663, 0, 0, 0};
      tab[13] = '{2, 0, 1, 29663, 1};

      for (int l = 0; l < NL; l++) begin
         reset[l]  = 1'b1;
         sig_in[l] = 1'b0;
      end
      cyc(1);
      for (int c = 0; c < 5; c++) begin
         for (int l = 0; l < NL; l++) sig_in[l] = (c % 2 == 0);
         cyc(1);
         for (int l = 0; l < NL; l++) chk_zero(l, $sformatf("rst%0d", c));
      end
      for (int l = 0; l < NL; l++) sig_in[l] = 1'b0;
      cyc(2);
      for (int l = 0; l < NL; l++) reset[l] = 1'b0;
      cyc(1);
      for (int l = 0; l < NL; l++) chk_zero(l, "rst_rel");

      fork
         run_table(0);
         run_table(1);
         run_table(2);
         run_fast();
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
